idecode_queue: RTL and testbench
================================

Name: idecode_queue

Overview:
Registered, parametrised instruction predecode queue between instruction fetch and the main execution state machine. Accepts fetched words over a valid/ready handshake and decodes each one on entry. The decode covers dispatch address, ReadE, condition code, I/O device and condition, interrupt jump/skip, and XCT. Decoded records sit in a DEPTH-entry FIFO that the execution FSM drains, and the queue self-flushes on redirect or on a user/userIO mode change.

Parameters:
DEPTH, 4, FIFO entries (power of 2, 2..16)
PC_W, 18, width of PC tag carried with each instruction
MODE_FLUSH, 1, 1 = auto-flush when user/userIO changes; 0 = ignore mode changes (exec-only builds)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  queue can accept (= ~full)
in_inst  in  36  instruction word
in_pc  in  PC_W  address of in_inst
user  in  1  current user mode
userIO  in  1  user I/O enabled
flush  in  1  discard all entries (PC redirect)
out_valid  out  1  head entry valid (= ~empty)
out_ready  in  1  execution FSM consumes head
out_inst  out  36  head instruction
out_pc  out  PC_W  head PC
dispatch  out  9  dispatch address
read_e  out  1  instruction reads C(E)
condition_code  out  3  skip/jump condition
io_dev  out  7  I/O device field
io_cond  out  1  device-conditions I/O
int_jump  out  1  interrupt instruction is a jump
int_skip  out  1  interrupt instruction is a skip
xct  out  1  XCT instruction
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: rd/wr pointers 0, count 0, out_valid 0, in_ready 1. All record outputs 0, with condition_code = skip_never. Reset beats flush and all handshakes in the same cycle. Reset mid-stream drops all entries.
- Enqueue when in_valid & in_ready. Decode is combinational on in_inst, user and userIO at the enqueue cycle, and the result is written into the entry.
- Latency: an entry accepted in cycle N is at the head no earlier than N+1. There is no same-cycle bypass.
- Dequeue when out_valid & out_ready. Record outputs are always driven from the head entry. When empty they are held at the reset values.
- Full: in_ready=0 even if a dequeue happens the same cycle, so there is no full-bypass.
- Simultaneous enqueue and dequeue when not full and not empty: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- flush: next cycle count=0 and out_valid=0. Any enqueue in the flush cycle is discarded.
- Mode flush (MODE_FLUSH=1): user and userIO are registered every cycle. If either differs from its registered value, treat the cycle as flush. An enqueue in that cycle is also discarded, because it was decoded against the old mode.
- Decode rules:
  - Defaults: dispatch = opcode, read_e=0, cc=skip_never, other flags 0.
  - read_e=1 for: byte ops IBP..DPB, non-I/M MOVx, mul/div except immediates, EXCH, XCT, PUSH, ADD/SUB non-I, CAM*, AOS*/SOS*/SKIP* (these also set int_skip), logical non-I, half-word non-I, TD*/TS*.
  - CAx/JUMPx/AOJx/AOSx/SOJx/SOSx/SKIPx take cc from opcode bits 6..8.
  - AOBJP uses skipge; AOBJN uses skipl.
  - PUSHJ, JSR, JSP set int_jump.
  - JRST, when not (user & ~userIO & (inst[9]|inst[10]|inst[12])): dispatch = 0o720 | inst[9:12], int_jump=1. Otherwise dispatch stays 0o254.
  - I/O opcodes (7xx): user & ~userIO gives dispatch 0o710. Otherwise dispatch = 0o700 + ioop.
    - BLKI/BLKO set int_skip; DATAO sets read_e.
    - CONO/CONI/CONSZ/CONSO set io_cond; CONSZ/CONSO also set int_skip, with cc skipe/skipn.
  - io_dev is always the instruction device field.

Decomposition:
- Shared package kv10_decode_pkg: opcode and I/O-op localparams, skip condition codes, the dispatch constants 0o700/0o710/0o720, and a packed decode_rec_t (dispatch, read_e, cc, io_dev, io_cond, int_jump, int_skip, xct).
- One combinational sub-module, idecode_rom (inst, user, userIO -> decode_rec_t).
- The FIFO stays in idecode_queue.

Test Plan:
- Exec mode, enqueue 36'o200040001000 (MOVE) -> next cycle out_valid=1, dispatch=0o200, read_e=1, cc=skip_never.
- user=1, userIO=0, JRST with inst[9]=1 -> dispatch=0o254, int_jump=0. Same word with userIO=1 -> dispatch=0o730, int_jump=1.
- Exec mode, CONSZ device 0o040 -> dispatch=0o706, cc=skipe, io_cond=1, int_skip=1, io_dev=0o040. Same word with user=1, userIO=0 -> dispatch=0o710.
- DEPTH=4, out_ready=0, 5 offers -> in_ready=0 after the 4th, count=4. Then out_ready=1 with in_valid=1 -> 5th accepted only once count=3, and FIFO order holds through pointer wrap.
- 3 entries queued, then toggle userIO -> count=0 next cycle and the same-cycle enqueue is dropped. Repeat with flush asserted, and with reset asserted mid-dequeue -> all outputs at reset values.

Source files
------------

// File: rtl/kv10_decode_pkg.sv
// KV10 predecode definitions: opcode/I-O-op codes, skip conditions, dispatch
// constants and the packed decode record carried by each queue entry.
package kv10_decode_pkg;

   localparam logic [8:0] OP_IBP   = 9'o133;
   localparam logic [8:0] OP_DPB   = 9'o137;
   localparam logic [8:0] OP_EXCH  = 9'o250;
   localparam logic [8:0] OP_AOBJP = 9'o252;
   localparam logic [8:0] OP_AOBJN = 9'o253;
   localparam logic [8:0] OP_JRST  = 9'o254;
   localparam logic [8:0] OP_XCT   = 9'o256;
   localparam logic [8:0] OP_PUSHJ = 9'o260;
   localparam logic [8:0] OP_PUSH  = 9'o261;
   localparam logic [8:0] OP_JSR   = 9'o264;
   localparam logic [8:0] OP_JSP   = 9'o265;

   localparam logic [2:0] IO_BLKI  = 3'd0;
   localparam logic [2:0] IO_DATAI = 3'd1;
   localparam logic [2:0] IO_BLKO  = 3'd2;
   localparam logic [2:0] IO_DATAO = 3'd3;
   localparam logic [2:0] IO_CONO  = 3'd4;
   localparam logic [2:0] IO_CONI  = 3'd5;
   localparam logic [2:0] IO_CONSZ = 3'd6;
   localparam logic [2:0] IO_CONSO = 3'd7;

   localparam logic [8:0] DISP_IO     = 9'o700;
   localparam logic [8:0] DISP_IOTRAP = 9'o710;
   localparam logic [8:0] DISP_JRST   = 9'o720;

   localparam logic [1:0] MODE_IMM = 2'd1;
   localparam logic [1:0] MODE_MEM = 2'd2;

   typedef enum logic [2:0] {
      SKIP_NEVER = 3'd0,
      SKIP_L     = 3'd1,
      SKIP_E     = 3'd2,
      SKIP_LE    = 3'd3,
      SKIP_A     = 3'd4,
      SKIP_GE    = 3'd5,
      SKIP_N     = 3'd6,
      SKIP_G     = 3'd7
   } skip_cc_t;

   typedef struct packed {
      logic [8:0] dispatch;
      logic       read_e;
      skip_cc_t   cc;
      logic [6:0] io_dev;
      logic       io_cond;
      logic       int_jump;
      logic       int_skip;
      logic       xct;
   } decode_rec_t;

endpackage

// File: rtl/idecode_rom.sv
// Combinational predecode of the instruction's opcode/AC field against the
// current user/userIO mode.
module idecode_rom
   import kv10_decode_pkg::*;
(
   input  logic [35:23]  inst_i,   // opcode (PDP bits 0..8) and AC (PDP bits 9..12)
   input  logic          user_i,
   input  logic          userio_i,
   output decode_rec_t   rec_o
);

   logic [8:0] op;
   logic [3:0] ac;
   logic [1:0] mode;
   logic [2:0] ioop;
   logic       io_trap;

   assign op      = inst_i[35:27];
   assign ac      = inst_i[26:23];
   assign mode    = op[1:0];
   assign ioop    = inst_i[25:23];
   assign io_trap = user_i & ~userio_i;

   always_comb begin
      rec_o          = '0;
      rec_o.cc       = SKIP_NEVER;
      rec_o.dispatch = op;
      rec_o.io_dev   = inst_i[32:26];

      if (op[8:6] == 3'o7) begin
         if (io_trap) begin
            rec_o.dispatch = DISP_IOTRAP;
         end else begin
            rec_o.dispatch = DISP_IO | {6'b0, ioop};
            case (ioop)
               IO_BLKI, IO_BLKO: rec_o.int_skip = 1'b1;
               IO_DATAO:         rec_o.read_e   = 1'b1;
               IO_CONO, IO_CONI: rec_o.io_cond  = 1'b1;
               IO_CONSZ: begin
                  rec_o.io_cond  = 1'b1;
                  rec_o.int_skip = 1'b1;
                  rec_o.cc       = SKIP_E;
               end
               IO_CONSO: begin
                  rec_o.io_cond  = 1'b1;
                  rec_o.int_skip = 1'b1;
                  rec_o.cc       = SKIP_N;
               end
               default: ;
            endcase
         end
      end else begin
         if (op >= OP_IBP && op <= OP_DPB)
            rec_o.read_e = 1'b1;
         // MOVx 200-217 and IMUL/MUL/IDIV/DIV 220-237 share the mode encoding
         if (op[8:4] == 5'b01000 && mode != MODE_IMM && mode != MODE_MEM)
            rec_o.read_e = 1'b1;
         if (op[8:4] == 5'b01001 && mode != MODE_IMM)
            rec_o.read_e = 1'b1;
         if (op[8:3] == 6'o27 && mode != MODE_IMM)
            rec_o.read_e = 1'b1;
         if ((op[8:6] == 3'o4 || op[8:6] == 3'o5) && mode != MODE_IMM)
            rec_o.read_e = 1'b1;
         if (op[8:6] == 3'o6 && op[3])
            rec_o.read_e = 1'b1;

         if (op[8:6] == 3'o3) begin
            rec_o.cc = skip_cc_t'(op[2:0]);
            case (op[5:3])
               3'o1:             rec_o.read_e = 1'b1;
               3'o3, 3'o5, 3'o7: begin
                  rec_o.read_e   = 1'b1;
                  rec_o.int_skip = 1'b1;
               end
               default: ;
            endcase
         end

         case (op)
            OP_EXCH, OP_PUSH: rec_o.read_e = 1'b1;
            OP_XCT: begin
               rec_o.read_e = 1'b1;
               rec_o.xct    = 1'b1;
            end
            OP_PUSHJ, OP_JSR, OP_JSP: rec_o.int_jump = 1'b1;
            OP_AOBJP: rec_o.cc = SKIP_GE;
            OP_AOBJN: rec_o.cc = SKIP_L;
            OP_JRST: begin
               // Halt/restore-flag forms stay on the generic JRST handler in user mode
               if (!(io_trap && (ac[3] || ac[2] || ac[0]))) begin
                  rec_o.dispatch = DISP_JRST | {5'b0, ac};
                  rec_o.int_jump = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/idecode_queue.sv
// Instruction predecode FIFO between fetch and the execution FSM; entries are
// decoded on entry and the queue self-flushes on redirect or mode change.
module idecode_queue
   import kv10_decode_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned PC_W       = 18,
   parameter bit          MODE_FLUSH = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [35:0]              in_inst,
   input  logic [PC_W-1:0]          in_pc,
   input  logic                     user,
   input  logic                     userIO,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [35:0]              out_inst,
   output logic [PC_W-1:0]          out_pc,
   output logic [8:0]               dispatch,
   output logic                     read_e,
   output logic [2:0]               condition_code,
   output logic [6:0]               io_dev,
   output logic                     io_cond,
   output logic                     int_jump,
   output logic                     int_skip,
   output logic                     xct,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          user_q, userio_q;

   decode_rec_t     rec_mem_q  [DEPTH];
   logic [35:0]     inst_mem_q [DEPTH];
   logic [PC_W-1:0] pc_mem_q   [DEPTH];

   decode_rec_t in_rec;
   decode_rec_t head_rec;
   logic        full, empty, mode_chg, flush_all, push, pop;

   idecode_rom u_rom (
      .inst_i   (in_inst[35:23]),
      .user_i   (user),
      .userio_i (userIO),
      .rec_o    (in_rec)
   );

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign count     = count_q;

   // A word offered during a mode switch was decoded under the old mode, so it is dropped too
   assign mode_chg  = MODE_FLUSH && ((user != user_q) || (userIO != userio_q));
   assign flush_all = flush | mode_chg;
   assign push      = in_valid & in_ready & ~flush_all;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_all) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      user_q   <= user;
      userio_q <= userIO;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rec_mem_q[wr_ptr_q]  <= in_rec;
         inst_mem_q[wr_ptr_q] <= in_inst;
         pc_mem_q[wr_ptr_q]   <= in_pc;
      end
   end

   always_comb begin
      head_rec    = '0;
      head_rec.cc = SKIP_NEVER;
      out_inst    = '0;
      out_pc      = '0;
      if (!empty) begin
         head_rec = rec_mem_q[rd_ptr_q];
         out_inst = inst_mem_q[rd_ptr_q];
         out_pc   = pc_mem_q[rd_ptr_q];
      end
   end

   assign dispatch       = head_rec.dispatch;
   assign read_e         = head_rec.read_e;
   assign condition_code = head_rec.cc;
   assign io_dev         = head_rec.io_dev;
   assign io_cond        = head_rec.io_cond;
   assign int_jump       = head_rec.int_jump;
   assign int_skip       = head_rec.int_skip;
   assign xct            = head_rec.xct;

endmodule

// File: tb/tb_idecode_queue.sv
// Directed bench for idecode_queue: decode cases, full/wrap ordering, and the
// three ways of emptying the queue (mode change, flush, reset).
module tb_idecode_queue;

   localparam int unsigned PC_W = 18;

   logic            clk = 1'b0;
   logic            reset, in_valid, in_ready, user, userIO, flush, out_valid, out_ready;
   logic [35:0]     in_inst, out_inst;
   logic [PC_W-1:0] in_pc, out_pc;
   logic [8:0]      dispatch;
   logic            read_e, io_cond, int_jump, int_skip, xct;
   logic [2:0]      condition_code;
   logic [6:0]      io_dev;
   logic [2:0]      count;

   int unsigned vec = 0;
   int unsigned err = 0;

   localparam logic [35:0] W_MOVE  = 36'o200040001000;
   localparam logic [35:0] W_JRST9 = {9'o254, 4'b1000, 23'd0};
   localparam logic [35:0] W_CONSZ = {3'o7, 7'o040, 3'd6, 23'd0};

   typedef struct packed {
      logic [8:0] op;
      logic [8:0] disp;
      logic       re;
      logic [2:0] cc;
      logic       jmp;
      logic       skp;
      logic       x;
   } dvec_t;

   dvec_t tbl [9] = '{
      '{9'o256, 9'o256, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1},   // XCT
      '{9'o375, 9'o375, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0},   // SOSGE
      '{9'o253, 9'o253, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0},   // AOBJN
      '{9'o271, 9'o271, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0},   // ADDI
      '{9'o260, 9'o260, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0},   // PUSHJ
      '{9'o612, 9'o612, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},   // TDNE
      '{9'o602, 9'o602, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0},   // TRNE
      '{9'o322, 9'o322, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0},   // JUMPE
      '{9'o230, 9'o230, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}    // IDIV
   };

   idecode_queue #(.DEPTH(4), .PC_W(PC_W), .MODE_FLUSH(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .user(user), .userIO(userIO), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .dispatch(dispatch), .read_e(read_e), .condition_code(condition_code),
      .io_dev(io_dev), .io_cond(io_cond), .int_jump(int_jump), .int_skip(int_skip),
      .xct(xct), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [35:0] w, input logic [PC_W-1:0] pc);
      in_valid = 1'b1;
      in_inst  = w;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic deq();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vec++; if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL reset_hs: got rdy/vld/cnt=%b/%b/%0d want 1/0/0", in_ready, out_valid, count); end
      vec++; if ({dispatch, read_e, condition_code, io_dev, io_cond, int_jump, int_skip, xct, out_inst, out_pc} !== '0) begin
         err++; $display("FAIL reset_rec: got disp=%o cc=%0d inst=%o pc=%o want all 0", dispatch, condition_code, out_inst, out_pc); end
   endtask

   task automatic test_move();
      in_valid = 1'b1;
      in_inst  = W_MOVE;
      in_pc    = 18'o1000;
      vec++; if (out_valid !== 1'b0) begin
         err++; $display("FAIL move_nobypass: got out_valid=%b want 0", out_valid); end
      tick();
      in_valid = 1'b0;
      vec++; if ({out_valid, dispatch, read_e, condition_code, count} !== {1'b1, 9'o200, 1'b1, 3'd0, 3'd1}) begin
         err++; $display("FAIL move_decode: got vld=%b disp=%o re=%b cc=%0d cnt=%0d want 1/200/1/0/1",
                         out_valid, dispatch, read_e, condition_code, count); end
      vec++; if ({out_inst, out_pc} !== {W_MOVE, 18'o1000}) begin
         err++; $display("FAIL move_head: got inst=%o pc=%o want %o/1000", out_inst, out_pc, W_MOVE); end
      deq();
      vec++; if ({out_valid, dispatch, read_e} !== {1'b0, 9'o000, 1'b0}) begin
         err++; $display("FAIL move_empty: got vld=%b disp=%o re=%b want 0/0/0", out_valid, dispatch, read_e); end
   endtask

   task automatic test_decode_table();
      for (int i = 0; i < 9; i++) begin
         enq({tbl[i].op, 27'd0}, PC_W'(i));
         vec++; if ({dispatch, read_e, condition_code, int_jump, int_skip, xct} !==
                    {tbl[i].disp, tbl[i].re, tbl[i].cc, tbl[i].jmp, tbl[i].skp, tbl[i].x}) begin
            err++; $display("FAIL decode_op%o: got disp=%o re=%b cc=%0d j=%b s=%b x=%b want disp=%o re=%b cc=%0d j=%b s=%b x=%b",
                            tbl[i].op, dispatch, read_e, condition_code, int_jump, int_skip, xct,
                            tbl[i].disp, tbl[i].re, tbl[i].cc, tbl[i].jmp, tbl[i].skp, tbl[i].x); end
         deq();
      end
   endtask

   task automatic test_jrst();
      user   = 1'b1;
      userIO = 1'b0;
      tick();
      enq(W_JRST9, 18'o10);
      vec++; if ({dispatch, int_jump} !== {9'o254, 1'b0}) begin
         err++; $display("FAIL jrst_user: got disp=%o jmp=%b want 254/0", dispatch, int_jump); end
      deq();
      userIO = 1'b1;
      tick();
      enq(W_JRST9, 18'o11);
      vec++; if ({dispatch, int_jump} !== {9'o730, 1'b1}) begin
         err++; $display("FAIL jrst_userio: got disp=%o jmp=%b want 730/1", dispatch, int_jump); end
      deq();
   endtask

   task automatic test_io();
      user   = 1'b0;
      userIO = 1'b0;
      tick();
      enq(W_CONSZ, 18'o20);
      vec++; if ({dispatch, condition_code, io_cond, int_skip, io_dev} !== {9'o706, 3'd2, 1'b1, 1'b1, 7'o040}) begin
         err++; $display("FAIL consz_exec: got disp=%o cc=%0d ioc=%b skp=%b dev=%o want 706/2/1/1/040",
                         dispatch, condition_code, io_cond, int_skip, io_dev); end
      deq();
      user = 1'b1;
      tick();
      enq(W_CONSZ, 18'o21);
      vec++; if ({dispatch, io_dev} !== {9'o710, 7'o040}) begin
         err++; $display("FAIL consz_user: got disp=%o dev=%o want 710/040", dispatch, io_dev); end
      deq();
      user = 1'b0;
      tick();
   endtask

   task automatic test_full_wrap();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_inst = {9'o200, 27'(k)};
         in_pc   = PC_W'(16 + k);
         tick();
      end
      vec++; if ({in_ready, count} !== {1'b0, 3'd4}) begin
         err++; $display("FAIL full_flag: got rdy=%b cnt=%0d want 0/4", in_ready, count); end
      in_inst = {9'o200, 27'd4};
      in_pc   = PC_W'(20);
      tick();
      vec++; if ({in_ready, count, out_pc} !== {1'b0, 3'd4, 18'd16}) begin
         err++; $display("FAIL full_hold: got rdy=%b cnt=%0d head=%0d want 0/4/16", in_ready, count, out_pc); end
      out_ready = 1'b1;
      tick();
      vec++; if ({count, out_pc} !== {3'd3, 18'd17}) begin
         err++; $display("FAIL full_nobypass: got cnt=%0d head=%0d want 3/17", count, out_pc); end
      tick();
      in_valid = 1'b0;
      vec++; if (count !== 3'd3) begin
         err++; $display("FAIL full_simul: got cnt=%0d want 3", count); end
      for (int k = 2; k < 5; k++) begin
         vec++; if ({out_valid, out_pc, out_inst} !== {1'b1, 18'(16 + k), 9'o200, 27'(k)}) begin
            err++; $display("FAIL wrap_order%0d: got vld=%b pc=%0d inst=%o want pc=%0d", k, out_valid, out_pc, out_inst, 16 + k); end
         tick();
      end
      out_ready = 1'b0;
      vec++; if ({out_valid, count} !== {1'b0, 3'd0}) begin
         err++; $display("FAIL wrap_drain: got vld=%b cnt=%0d want 0/0", out_valid, count); end
   endtask

   task automatic test_mode_flush();
      for (int k = 1; k <= 3; k++) enq(W_MOVE, PC_W'(k));
      vec++; if (count !== 3'd3) begin
         err++; $display("FAIL mode_fill: got cnt=%0d want 3", count); end
      userIO   = 1'b1;
      in_valid = 1'b1;
      in_inst  = W_MOVE;
      in_pc    = 18'd7;
      tick();
      in_valid = 1'b0;
      vec++; if ({count, out_valid, dispatch} !== {3'd0, 1'b0, 9'o0}) begin
         err++; $display("FAIL mode_flush: got cnt=%0d vld=%b disp=%o want 0/0/0", count, out_valid, dispatch); end
      tick();
      vec++; if (count !== 3'd0) begin
         err++; $display("FAIL mode_drop: got cnt=%0d want 0", count); end
      userIO = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      for (int k = 1; k <= 3; k++) enq(W_MOVE, PC_W'(k));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_pc    = 18'd9;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      vec++; if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
         err++; $display("FAIL flush_empty: got cnt=%0d vld=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
      tick();
      vec++; if (count !== 3'd0) begin
         err++; $display("FAIL flush_drop: got cnt=%0d want 0", count); end
      enq(W_CONSZ, 18'd42);
      vec++; if ({count, out_pc, dispatch} !== {3'd1, 18'd42, 9'o706}) begin
         err++; $display("FAIL flush_resume: got cnt=%0d pc=%0d disp=%o want 1/42/706", count, out_pc, dispatch); end
      deq();
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k <= 3; k++) enq(W_MOVE, PC_W'(k));
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pc     = 18'd5;
      tick();
      reset     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      vec++; if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL rstmid_hs: got rdy/vld/cnt=%b/%b/%0d want 1/0/0", in_ready, out_valid, count); end
      vec++; if ({dispatch, read_e, condition_code, io_dev, io_cond, int_jump, int_skip, xct, out_inst, out_pc} !== '0) begin
         err++; $display("FAIL rstmid_rec: got disp=%o re=%b pc=%o want all 0", dispatch, read_e, out_pc); end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      user      = 1'b0;
      userIO    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_move();
      test_decode_table();
      test_jrst();
      test_io();
      test_full_wrap();
      test_mode_flush();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
